// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the byte-wide RAM port to IF or MEM and sequences
// each request into 1-4 byte accesses, assembling reads little-endian.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           4-byte fetch request (held until if_done)
//   if_done/if_data          one-cycle completion pulse and fetched word
//   mem_req/mem_rw/mem_addr  load/store request (held until mem_done)
//   mem_len/mem_wdata        byte count minus one, store data
//   mem_done/mem_rdata       one-cycle completion pulse, zero-filled load data
//   ram_rw/ram_addr/ram_dout RAM command, byte address, write data
//   ram_din                  RAM read data, one cycle after the address
//
// Build option: define MEMARB_IF_FAIR_EN for round-robin arbitration
// when both requests are pending; otherwise MEM has strict priority.

module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        n_q;
    logic [2:0]        k_q;
    logic              own_mem_q;
    logic [31:0]       asm_q;
    logic [31:0]       wdata_q;

    logic              grant_mem;
    logic              grant_if;
    logic [1:0]        cap_idx;

    // Byte returned this cycle belongs to the address issued last cycle.
    assign cap_idx = k_q[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        ram_rw    = 1'b0;
        ram_addr  = '0;
        ram_dout  = '0;
        if_done   = 1'b0;
        if_data   = '0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        unique case (state_q)
            S_IDLE: begin
`ifdef MEMARB_IF_FAIR_EN
                // On contention, the previous non-owner wins.
                grant_mem = mem_req && (!if_req || !own_mem_q);
`else
                grant_mem = mem_req;
`endif
                grant_if = if_req && !grant_mem;
                if (grant_mem) begin
                    state_d = mem_rw ? S_WR : S_RD;
                end else if (grant_if) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // k == n is a capture-only cycle for the last byte.
                if (k_q < n_q) begin
                    ram_addr = base_q + ADDR_W'(k_q);
                end
                if (k_q == n_q) begin
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                ram_rw   = 1'b1;
                ram_addr = base_q + ADDR_W'(k_q);
                ram_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
                if (k_q == n_q - 3'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (own_mem_q) begin
                    mem_done  = 1'b1;
                    mem_rdata = asm_q;
                end else begin
                    if_done = 1'b1;
                    if_data = asm_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            n_q       <= '0;
            k_q       <= '0;
            own_mem_q <= 1'b1;
            asm_q     <= '0;
            wdata_q   <= '0;
        end else if (grant_mem) begin
            base_q    <= mem_addr;
            n_q       <= {1'b0, mem_len} + 3'd1;
            k_q       <= '0;
            own_mem_q <= 1'b1;
            asm_q     <= '0;
            wdata_q   <= mem_wdata;
        end else if (grant_if) begin
            base_q    <= if_addr;
            n_q       <= 3'd4;
            k_q       <= '0;
            own_mem_q <= 1'b0;
            asm_q     <= '0;
            wdata_q   <= '0;
        end else if (state_q == S_RD) begin
            if (k_q != 3'd0) begin
                asm_q[{cap_idx, 3'b000} +: 8] <= ram_din;
            end
            k_q <= k_q + 3'd1;
        end else if (state_q == S_WR) begin
            k_q <= k_q + 3'd1;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential byte-RAM arbiter and word sequencer between the instruction-fetch stage and the MEM stage. It grants the single byte-wide RAM port to one requester at a time. Each request is broken into 1–4 consecutive byte accesses, with read bytes assembled little-endian into a 32-bit word. It sits where the combinational IF/MEM-to-RAM mux sits today, so IF and MEM no longer handle per-byte sequencing themselves.

## Interface
- ADDR_W, 32: address width for all address buses.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- if_req  in  1  IF requests a 4-byte instruction fetch; held with if_addr stable until if_done.
- if_addr  in  ADDR_W  fetch base address.
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  out  32  fetched word, byte0 from if_addr in bits [7:0].
- mem_req  in  1  MEM requests a load/store; held with all operands stable until mem_done.
- mem_rw  in  1  0 = load, 1 = store.
- mem_addr  in  ADDR_W  access base address.
- mem_len  in  2  byte count minus one (00 = 1, 01 = 2, 11 = 4; 10 = 3, unused by the core).
- mem_wdata  in  32  store data, byte k taken from bits [8k+7:8k].
- mem_done  out  1  one-cycle pulse; mem_rdata valid in the same cycle for loads.
- mem_rdata  out  32  load data, zero-filled above the length. Sign extension is done in MEM.
- ram_rw  out  1  0 = read, 1 = write.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_dout  out  8  write data to RAM.
- ram_din  in  8  read data. Data for the address presented in cycle t is valid in cycle t+1.

## Operation
- States:
  - IDLE: no transfer in progress.
  - RD: issues read addresses and captures returned bytes.
  - WR: issues write addresses and data.
  - DONE: signals completion for one cycle.
- Registers: base address, byte count n (1–4), issue counter k (0–4), owner (IF/MEM), and a 32-bit assembly register.
- IDLE arbitration: at a rising edge, if mem_req is high, grant MEM; otherwise, if if_req is high, grant IF. On grant, latch the operands and set k = 0.
  - MEM load or any IF request → RD.
  - MEM store → WR.
- RD: ram_rw = 0 and ram_addr = base + k while k < n. On each edge:
  - if k ≥ 1, capture ram_din into byte k−1;
  - then k ← k + 1;
  - when k = n at the edge, capture byte n−1 and go to DONE.
- WR: ram_rw = 1, ram_addr = base + k, ram_dout = wdata byte k. On each edge k ← k + 1; after byte n−1 is written, go to DONE.
- DONE: the owner's done output is 1 and its data output holds the assembled word. Next state is IDLE unconditionally. No grant is made in DONE, so a stale req is never re-accepted; the requester must drop or change req by the end of DONE.
- Address arithmetic is base + k modulo 2^ADDR_W; wrap past all-ones continues at 0. Misaligned bases are legal.
- Outside RD/WR: ram_rw = 0, ram_addr = 0, ram_dout = 0.
- Unused bytes of mem_rdata are 0. The assembly register is cleared on each grant.

## Timing
- Reset values: if_done = 0, mem_done = 0, if_data = 0, mem_rdata = 0, ram_rw = 0, ram_addr = 0, ram_dout = 0; state = IDLE; owner = MEM; k = 0.
- Read latency: req sampled at edge E0; addresses driven in the n cycles after E0; done high in the cycle after edge E0+n+1.
  - 4-byte fetch: done in the 6th cycle after E0, n+2 = 6 cycles of occupancy.
- Write latency: done high in the cycle after edge E0+n.
- Back-to-back: minimum gap is one cycle (DONE) plus one IDLE edge between transfers.
- rst mid-transfer: return to IDLE at that edge with no done pulse. RAM bytes already written stay written.
- Simultaneous requests: MEM wins (default build). IF waits with if_req held.

## Configuration
- MEMARB_IF_FAIR_EN:
  - Defined: round-robin grant. When both requests are high in IDLE, the grant goes to the requester that did not own the previous transfer. A lone requester is always granted.
  - Undefined: strict MEM priority as described above.

## Test plan
- IF fetch at 0x00001000 with RAM bytes 0x13,0x05,0x10,0x00 → ram_addr 0x1000..0x1003 on consecutive cycles, if_data = 0x00100513, if_done pulses once, 6 cycles after the grant edge.
- MEM 1-byte load from 0x20 holding 0xF0 → mem_rdata = 0x000000F0, mem_done on cycle 3.
- MEM 2-byte store 0xBEEF to 0xFFFFFFFF → writes 0xEF at 0xFFFFFFFF, then 0xBE at 0x00000000; ram_rw = 1 for exactly 2 cycles.
- if_req and mem_req asserted at the same edge → MEM served first, then IF. With MEMARB_IF_FAIR_EN and the previous owner MEM, IF is served first.
- rst asserted in the second RD cycle of a 4-byte load → next cycle in IDLE, all outputs 0, no mem_done. A fresh request after reset completes normally.
- if_req held through DONE for one extra cycle → exactly one if_done pulse; no duplicate fetch is started.
